// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encodings and the iteration-counter width.
package div_pkg;

    localparam int DIV_WIDTH = 8;
    localparam int CNT_W     = $clog2(DIV_WIDTH + 1);

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_FIN  = 2'd2
    } div_state_e;

    // Counter width for an arbitrary operand width (CNT_W is the 8-bit case).
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/cla_subtractor.sv
// Lookahead subtractor: diff = a + ~b + 1, with every carry expanded as a
// generate/propagate sum of products; borrow is the inverted carry-out.
module cla_subtractor #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);
    logic [N-1:0] nb, g, p;
    logic [N:0]   c;

    assign nb = ~b;
    assign g  = a & nb;
    assign p  = a ^ nb;

    always_comb begin
        logic pp;
        // NOTE: every variable written here gets a default first, so no path leaves a latch.
        c    = '0;
        pp   = 1'b0;
        c[0] = 1'b1;
        for (int i = 0; i < N; i++) begin
            c[i+1] = g[i];
            pp     = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pp & g[j]);
                pp     = pp & p[j];
            end
            c[i+1] = c[i+1] | pp;   // carry-in of 1 from the two's-complement +1
        end
    end

    assign diff   = p ^ c[N-1:0];
    assign borrow = ~c[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// Radix-2 restoring unsigned divider, one trial subtraction per clock,
// start/busy/done handshake. Optional macro DIVZERO_DETECT_EN adds div_zero.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
`ifdef DIVZERO_DETECT_EN
    output logic             div_zero,
`endif
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = cnt_width(WIDTH);

    div_state_e       state;
    logic [WIDTH-1:0] r_q, q_q, d_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   trial_a, trial_b, diff;
    logic             sub_borrow;
    logic             unused_diff_msb;
`ifdef DIVZERO_DETECT_EN
    logic             dz_q;
`endif

    // Shifted partial remainder keeps the bit that leaves R as its MSB, so a
    // divisor with its top bit set still compares correctly.
    assign trial_a = {r_q, q_q[WIDTH-1]};
    assign trial_b = {1'b0, d_q};

    cla_subtractor #(.N(WIDTH + 1)) u_sub (
        .a      (trial_a),
        .b      (trial_b),
        .diff   (diff),
        .borrow (sub_borrow)
    );

    // A non-borrowing difference is below the divisor, so its MSB is always 0.
    assign unused_diff_msb = diff[WIDTH];

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= DIV_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            r_q       <= '0;
            q_q       <= '0;
            d_q       <= '0;
            cnt       <= '0;
`ifdef DIVZERO_DETECT_EN
            div_zero  <= 1'b0;
            dz_q      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        d_q <= divisor;
                        cnt <= CW'(WIDTH);
`ifdef DIVZERO_DETECT_EN
                        div_zero <= 1'b0;
                        if (divisor == '0) begin
                            r_q   <= dividend;
                            q_q   <= '1;
                            dz_q  <= 1'b1;
                            state <= DIV_FIN;
                        end else begin
                            r_q   <= '0;
                            q_q   <= dividend;
                            dz_q  <= 1'b0;
                            busy  <= 1'b1;
                            state <= DIV_RUN;
                        end
`else
                        r_q   <= '0;
                        q_q   <= dividend;
                        busy  <= 1'b1;
                        state <= DIV_RUN;
`endif
                    end
                end
                DIV_RUN: begin
                    r_q <= sub_borrow ? trial_a[WIDTH-1:0] : diff[WIDTH-1:0];
                    q_q <= {q_q[WIDTH-2:0], ~sub_borrow};
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        busy  <= 1'b0;
                        state <= DIV_FIN;
                    end
                end
                DIV_FIN: begin
                    quotient  <= q_q;
                    remainder <= r_q;
                    done      <= 1'b1;
`ifdef DIVZERO_DETECT_EN
                    div_zero  <= dz_q;
`endif
                    state     <= DIV_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and random self-checking bench for seq_restoring_divider (WIDTH=8);
// follows DIVZERO_DETECT_EN when the macro is defined for the build.
module tb_seq_restoring_divider;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend, divisor;
    logic       busy, done;
    logic [7:0] quotient, remainder;
`ifdef DIVZERO_DETECT_EN
    logic       div_zero;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_restoring_divider #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
`ifdef DIVZERO_DETECT_EN
        .div_zero  (div_zero),
`endif
        .remainder (remainder)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // done and busy must never be high together.
    always @(negedge clk) begin
        if (rst_n === 1'b1) check("done_busy_overlap", {31'd0, done & busy}, 32'd0);
    end

    function automatic int exp_latency(input logic [7:0] b);
`ifdef DIVZERO_DETECT_EN
        if (b == 8'd0) return 2;
`endif
        return 10;
    endfunction

    // Called at a negedge; returns at the negedge of the done cycle so the
    // next call can issue a back-to-back start.
    task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] eq, input logic [7:0] er,
                           input int poke, input string tag);
        int k;
        int busy_cnt;
        int el;
        el       = exp_latency(b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        k        = 1;
        busy_cnt = 0;
        while (done !== 1'b1 && k < 40) begin
            if (busy === 1'b1) busy_cnt++;
            if (k == poke) begin
                start    = 1'b1;
                dividend = 8'hFF;
                divisor  = 8'h01;
            end else if (k == poke + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        check({tag, " latency"}, k, el);
        check({tag, " busy_cycles"}, busy_cnt, el - 2);
        check({tag, " quotient"}, {24'd0, quotient}, {24'd0, eq});
        check({tag, " remainder"}, {24'd0, remainder}, {24'd0, er});
`ifdef DIVZERO_DETECT_EN
        check({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, (b == 8'd0)});
`endif
    endtask

    initial begin
        int dones;
        logic [7:0] ra, rb, rq, rr;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset quotient", {24'd0, quotient}, 32'd0);
        check("reset remainder", {24'd0, remainder}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_div(8'd100, 8'd7, 8'd14, 8'd2, -1, "100/7");
        @(negedge clk);
        check("done_width", {31'd0, done}, 32'd0);
        check("hold quotient", {24'd0, quotient}, 32'd14);
        run_div(8'd255, 8'd1, 8'd255, 8'd0, -1, "255/1");
        run_div(8'd5, 8'd9, 8'd0, 8'd5, -1, "5/9");
        run_div(8'd200, 8'd200, 8'd1, 8'd0, -1, "200/200");
        run_div(8'd255, 8'd200, 8'd1, 8'd55, -1, "255/200");
        run_div(8'd129, 8'd255, 8'd0, 8'd129, -1, "129/255");

        // Back-to-back: the second start lands in the first done cycle.
        run_div(8'd60, 8'd4, 8'd15, 8'd0, -1, "60/4");
        run_div(8'd61, 8'd4, 8'd15, 8'd1, -1, "61/4");

        // Start and operand change mid-RUN must be ignored.
        run_div(8'd50, 8'd3, 8'd16, 8'd2, 3, "50/3 poke");
        @(negedge clk);

        run_div(8'd77, 8'd0, 8'd255, 8'd77, -1, "77/0");
        @(negedge clk);

        // Reset during RUN cycle 4 aborts with no later done.
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort quotient", {24'd0, quotient}, 32'd0);
        check("abort remainder", {24'd0, remainder}, 32'd0);
        rst_n = 1'b1;
        dones = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        check("abort no_done", dones, 0);

        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = (i % 50 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            if (rb == 8'd0) begin
                rq = 8'hFF;
                rr = ra;
            end else begin
                rq = ra / rb;
                rr = ra % rb;
            end
            run_div(ra, rb, rq, rr, -1, "random");
        end
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
